// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Takes bytes handed over by the UART receiver's flag/clear handshake and
//   queues them, together with their parity-error bit, in a first-word-fall-
//   through FIFO. The host drains the FIFO with a read strobe. A sticky
//   overrun flag and a saturating parity-error counter are kept for the host.
//
// Parameters
//   DEPTH            FIFO entries (power of two, >= 2)
//   ADDR_W           log2(DEPTH)
//   DROP_PARITY_ERR  1: parity-error frames are counted but not stored
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flag_data_received  receiver has a byte, held until clear_flag
//   flag_parity_error   parity error for the flagged byte
//   data_in             received byte
//   clear_flag          acknowledge back to the receiver (high in ACK)
//   rd_en               host pops the head entry this cycle
//   rd_data             head entry data, 8'h00 when empty
//   rd_parity_err       head entry parity flag, 0 when empty
//   empty, full, count  FIFO occupancy
//   overrun             sticky: a byte was lost on a full FIFO
//   overrun_clr         clears overrun (a new overrun wins)
//   parity_err_cnt      saturating count of parity-error frames
module uart_rx_fifo #(
  parameter int DEPTH           = 8,
  parameter int ADDR_W          = 3,
  parameter bit DROP_PARITY_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_data_received,
  input  logic              flag_parity_error,
  input  logic [7:0]        data_in,
  output logic              clear_flag,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_parity_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [7:0]        parity_err_cnt
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  state_t            state, state_next;
  logic [8:0]        mem [DEPTH];
  logic [8:0]        head;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              capture, store, do_read, do_write, lost;

  // Capture FSM: one write attempt per flag assertion; ACK holds clear_flag
  // until the receiver drops its flag.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (flag_data_received)  state_next = ACK;
      ACK:  if (!flag_data_received) state_next = IDLE;
    endcase
  end

  assign clear_flag = (state == ACK);

  assign capture  = (state == IDLE) && flag_data_received;
  assign store    = capture && !(DROP_PARITY_ERR && flag_parity_error);
  assign do_read  = rd_en && !empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign do_write = store && (!full || do_read);
  assign lost     = store && full && !do_read;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {flag_parity_error, data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (do_write && !do_read)      count <= count + (ADDR_W+1)'(1);
      else if (do_read && !do_write) count <= count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
    end else begin
      if (lost)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (capture && flag_parity_error && parity_err_cnt != 8'hFF)
        parity_err_cnt <= parity_err_cnt + 8'd1;
    end
  end

  assign head          = mem[rd_ptr];
  assign rd_data       = empty ? 8'h00 : head[7:0];
  assign rd_parity_err = empty ? 1'b0  : head[8];

endmodule
